fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have one clock, `clk`, and an asynchronous active-low reset, `rst_n`.
REQ-003 Ports (name, direction, width, meaning):
- `clk`, in, 1, rising-edge clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `imem_req_valid`, out, 1, fetch request.
- `imem_req_ready`, in, 1, memory accepts the request.
- `imem_req_addr`, out, 32, word-aligned fetch address.
- `imem_rsp_valid`, in, 1, instruction word returned.
- `imem_rsp_data`, in, 32, instruction word.
- `instr_valid`, out, 1, queue head valid toward the decoder.
- `instr_ready`, in, 1, decoder consumes the head.
- `instr`, out, 32, head instruction word.
- `instr_pc`, out, 32, PC of the head instruction.
- `redirect_valid`, in, 1, taken branch/jump from execute.
- `redirect_pc`, in, 32, target PC.

Function
REQ-004 SHALL keep a 32-bit fetch PC and a 2-entry instruction queue holding {instr, pc} pairs.
REQ-005 SHALL allow at most one outstanding memory request.
REQ-006 SHALL implement an FSM with three states: FETCH, WAIT and DROP.
REQ-007 In FETCH, `imem_req_valid` SHALL equal 1 when queue count < 2; `imem_req_addr` SHALL equal PC.
REQ-008 Once `imem_req_valid` is asserted, it and `imem_req_addr` SHALL hold stable until `imem_req_ready`, unless a redirect occurs.
REQ-009 FETCH to WAIT SHALL occur on `imem_req_valid` & `imem_req_ready`.
REQ-010 In WAIT, on `imem_rsp_valid`, the block SHALL push {`imem_rsp_data`, PC} into the queue, set PC to PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) and return to FETCH.
REQ-011 `imem_rsp_valid` SHALL be ignored in FETCH.
REQ-012 In DROP, `imem_rsp_valid` SHALL be discarded, with DROP going to FETCH.
REQ-013 `instr_valid` SHALL equal (count != 0); `instr` and `instr_pc` SHALL present the queue head.
REQ-014 The head SHALL pop on `instr_valid` & `instr_ready`.
REQ-015 A push and a pop in the same cycle SHALL leave count unchanged, with order preserved.
REQ-016 The queue SHALL never overflow: issue is gated by count < 2, and count cannot rise while a request is outstanding.
REQ-017 On `redirect_valid`, next cycle: the queue SHALL be flushed (count=0) and PC SHALL be {`redirect_pc[31:2]`, 2'b00}. Any pop in that cycle is irrelevant.
REQ-018 Redirect in FETCH with no handshake SHALL stay in FETCH, with the new address issued next cycle.
REQ-019 Redirect in FETCH coincident with a request handshake SHALL go to DROP (the old-address request is accepted, its response discarded).
REQ-020 Redirect in WAIT without `imem_rsp_valid` SHALL go to DROP.
REQ-021 Redirect in WAIT coincident with `imem_rsp_valid` SHALL discard the response and go to FETCH.
REQ-022 Redirect in DROP SHALL update PC. It SHALL stay in DROP, or go to FETCH if `imem_rsp_valid` arrives in the same cycle.
REQ-023 Redirect SHALL take priority over push and pc+4 update in every state.
REQ-024 Best-case throughput SHALL be one instruction per 2 cycles (request cycle + response cycle).

Reset
REQ-025 While `rst_n`=0 (asynchronous): state=FETCH, PC=RESET_PC, count=0, queue pointers=0, `instr_valid`=0, `imem_req_valid`=0.
REQ-026 `imem_req_valid` SHALL assert in the first clock after `rst_n` rises.
REQ-027 Reset asserted mid-WAIT or mid-DROP SHALL abandon the outstanding transaction; the memory side is reset by the same `rst_n`.
REQ-028 Queue data registers need no reset.

Structure
REQ-029 The shared package SHALL hold the fetch FSM state enum (FETCH, WAIT, DROP), XLEN=32, INSTR_BYTES=4 and the default RESET_PC constant.
REQ-030 The queue SHALL be a sub-module `fetch_queue` (parameter DEPTH=2, width 64).
- Ports: push, pop, flush, full, empty, count, head.
- flush SHALL have priority over push.
REQ-031 The FSM, PC register and output assignments SHALL reside in `fetch_unit`.

Verification
REQ-032 Reset, then mem ready=1, 1-cycle response, `instr_ready`=1 -> requests at 0x0, 0x4, 0x8 every 2 cycles; `instr_pc` sequence 0x0, 0x4, 0x8.
REQ-033 `instr_ready`=0 throughout -> exactly two instructions queued (pc 0x0, 0x4); `imem_req_valid` stays 0 afterwards; release `instr_ready` -> both pop in order, then fetch resumes at 0x8.
REQ-034 Redirect to 0x100 while in WAIT for 0x8 -> DROP; the 0x8 response is discarded; the next request is at 0x100; `instr_valid`=0 until the 0x100 instruction arrives.
REQ-035 Redirect to 0x203 coincident with a response -> the response is discarded; the next request is at 0x200.
REQ-036 `imem_req_ready` held low 5 cycles -> `imem_req_valid` and address stay stable all 5 cycles.
REQ-037 RESET_PC=32'hFFFF_FFFC -> first `instr_pc` is 0xFFFF_FFFC and the next request is at 0x0000_0000; `rst_n` pulsed low during WAIT -> outputs immediately take reset values.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch FSM state, widths and reset PC for the fetch unit
package fetch_unit_pkg;
   localparam int XLEN = 32;
   localparam int INSTR_BYTES = 4;
   localparam int QUEUE_DEPTH = 2;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef enum logic [1:0] {FETCH, WAIT, DROP} fetch_state_t;
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO of {instr, pc} entries between fetch and decode
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : enqueue one entry
//   pop                 : dequeue the head (ignored when empty)
//   flush               : drop all entries; wins over push
//   full, empty, count  : occupancy
//   head                : oldest entry
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [WIDTH-1:0]             head
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic do_push, do_pop;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction
   assign empty = count == '0;
   assign full = count == CW'(DEPTH);
   assign do_pop = pop & ~empty;
   // a full queue can still accept a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign head = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= inc(wr_ptr);
         if (do_pop) rd_ptr <= inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push & ~flush) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a 2-entry queue
//   clk, rst_n                      : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       : fetch request toward instruction memory
//   imem_rsp_valid/data             : returned instruction word
//   instr_valid/ready, instr, instr_pc : queue head toward the decoder
//   redirect_valid, redirect_pc     : taken branch/jump from execute
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);
   fetch_state_t state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic req_fire, push, pop, full, empty;
   logic [1:0] count;
   fetch_entry_t head;
   assign req_fire = imem_req_valid & imem_req_ready;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= FETCH;
         pc <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc <= pc_nxt;
      end
   // a redirect while a request is in flight parks in DROP until its response is swallowed
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   state_nxt = req_fire ? (redirect_valid ? DROP : WAIT) : FETCH;
         WAIT:    state_nxt = imem_rsp_valid ? FETCH : (redirect_valid ? DROP : WAIT);
         DROP:    state_nxt = imem_rsp_valid ? FETCH : DROP;
         default: state_nxt = FETCH;
      endcase
   end
   always_comb begin
      // rst_n keeps the request low while reset is held, since state alone already reads FETCH
      imem_req_valid = rst_n & (state == FETCH) & ~full;
      push = (state == WAIT) & imem_rsp_valid & ~redirect_valid;
      pop = instr_ready & ~empty;
      instr_valid = count != '0;
      pc_nxt = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc + XLEN'(INSTR_BYTES) : pc;
   end
   assign imem_req_addr = pc;
   assign instr = head.instr;
   assign instr_pc = head.pc;
   fetch_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(2*XLEN)) u_queue (
      .clk(clk),
      .rst_n(rst_n),
      .push(push),
      .push_data({imem_rsp_data, pc}),
      .pop(pop),
      .flush(redirect_valid),
      .full(full),
      .empty(empty),
      .count(count),
      .head(head)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-controlled memory model
module tb_fetch_unit;
   logic clk = 0;
   logic rst_n = 0;
   always #5 clk = ~clk;
   logic imem_req_valid, imem_req_ready, imem_rsp_valid, instr_valid, instr_ready, redirect_valid;
   logic [31:0] imem_req_addr, imem_rsp_data, instr, instr_pc, redirect_pc;
   logic w_req_valid, w_req_ready, w_rsp_valid, w_instr_valid, w_instr_ready, w_redirect_valid;
   logic [31:0] w_req_addr, w_rsp_data, w_instr, w_instr_pc, w_redirect_pc;
   int checks = 0;
   int failures = 0;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];
   bit pend, pend_drop;
   logic [31:0] pend_addr, last_pc;
   int cnt, lat, pops;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc),
      .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // one clock: account for handshakes about to happen, cross the edge, drive memory response
   task automatic step();
      exp_t e;
      logic hs;
      hs = imem_req_valid & imem_req_ready;
      if (instr_valid && instr_ready && !redirect_valid) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected got pc=%h instr=%h with nothing expected", instr_pc, instr);
         end else begin
            e = sb.pop_front();
            if (instr_pc !== e.pc || instr !== e.data) begin
               failures++;
               $display("FAIL pop_order got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, e.pc, e.data);
            end
            pops++;
            last_pc = instr_pc;
         end
      end
      if (imem_rsp_valid) begin
         if (!pend_drop && !redirect_valid) sb.push_back({pend_addr, imem_rsp_data});
         pend = 0;
      end
      if (redirect_valid) begin
         sb.delete();
         pend_drop = 1;
      end
      if (hs) begin
         checks++;
         if (pend) begin
            failures++;
            $display("FAIL one_outstanding new request at %h while %h pending", imem_req_addr, pend_addr);
         end
         pend = 1;
         pend_addr = imem_req_addr;
         pend_drop = redirect_valid;
         cnt = lat;
      end
      @(posedge clk);
      #1;
      redirect_valid = 0;
      imem_rsp_valid = 0;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            imem_rsp_valid = 1;
            imem_rsp_data = mem_word(pend_addr);
         end
      end
   endtask

   task automatic wait_req(input logic [31:0] exp, input string name);
      int n = 0;
      while (!(imem_req_valid && imem_req_ready) && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (!(imem_req_valid && imem_req_ready)) begin
         failures++;
         $display("FAIL %s no request within 20 cycles, expected addr %h", name, exp);
      end else if (imem_req_addr !== exp) begin
         failures++;
         $display("FAIL %s req_addr=%h expected %h", name, imem_req_addr, exp);
      end
   endtask

   task automatic drain(input string name, input int exp_pops, input logic [31:0] exp_last);
      int n = 0;
      imem_req_ready = 0;
      instr_ready = 1;
      while ((sb.size() != 0 || pend) && n < 30) begin
         step();
         n++;
      end
      checks++;
      if (sb.size() != 0 || pend || pops != exp_pops || last_pc !== exp_last) begin
         failures++;
         $display("FAIL %s pops=%0d last_pc=%h left=%0d expected pops=%0d last_pc=%h left=0",
                  name, pops, last_pc, sb.size(), exp_pops, exp_last);
      end
   endtask

   task automatic reset_all();
      rst_n = 0;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
      instr_ready = 0; redirect_valid = 0; redirect_pc = 0;
      w_req_ready = 1; w_rsp_valid = 0; w_rsp_data = 0;
      w_instr_ready = 0; w_redirect_valid = 0; w_redirect_pc = 0;
      sb.delete(); pend = 0; pend_drop = 0; lat = 1; pops = 0; last_pc = 'x;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL in_reset req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid);
      end
      rst_n = 1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         failures++;
         $display("FAIL after_reset req_valid=%b addr=%h expected 1 00000000", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_reset();
      reset_all();
      step();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle req_valid=%b addr=%h instr_valid=%b expected 1 00000000 0",
                  imem_req_valid, imem_req_addr, instr_valid);
      end
   endtask

   task automatic test_stream();
      reset_all();
      imem_req_ready = 1;
      instr_ready = 1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (imem_req_valid !== ((i % 2) == 0)) begin
            failures++;
            $display("FAIL stream_valid cycle %0d req_valid=%b expected %b", i, imem_req_valid, (i % 2) == 0);
         end else if ((i % 2) == 0 && imem_req_addr !== 32'(i * 2)) begin
            failures++;
            $display("FAIL stream_addr cycle %0d addr=%h expected %h", i, imem_req_addr, 32'(i * 2));
         end
         step();
      end
      drain("stream_drain", 3, 32'h8);
   endtask

   task automatic test_full();
      reset_all();
      imem_req_ready = 1;
      instr_ready = 0;
      for (int i = 0; i < 8; i++) begin
         if (i >= 4) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
               failures++;
               $display("FAIL full_no_issue cycle %0d req_valid=%b expected 0", i, imem_req_valid);
            end
         end
         step();
      end
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
         failures++;
         $display("FAIL full_head instr_valid=%b pc=%h expected 1 00000000", instr_valid, instr_pc);
      end
      instr_ready = 1;
      wait_req(32'h8, "full_resume");
      drain("full_drain", 2, 32'h4);
   endtask

   task automatic test_redirect_wait();
      reset_all();
      imem_req_ready = 1;
      instr_ready = 0;
      wait_req(32'h0, "rw_req0");
      step(); step();
      wait_req(32'h4, "rw_req4");
      step(); step();
      instr_ready = 1;
      step();
      instr_ready = 0;
      lat = 3;
      wait_req(32'h8, "rw_req8");
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
         failures++;
         $display("FAIL rw_queued instr_valid=%b pc=%h expected 1 00000004", instr_valid, instr_pc);
      end
      redirect_valid = 1;
      redirect_pc = 32'h100;
      step();
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL rw_drop req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid);
      end
      lat = 1;
      wait_req(32'h100, "rw_req100");
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL rw_flushed instr_valid=%b expected 0", instr_valid);
      end
      step(); step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
         failures++;
         $display("FAIL rw_target instr_valid=%b pc=%h expected 1 00000100", instr_valid, instr_pc);
      end
      drain("rw_drain", 2, 32'h100);
   endtask

   task automatic test_redirect_rsp();
      reset_all();
      imem_req_ready = 1;
      instr_ready = 1;
      wait_req(32'h0, "rr_req0");
      step();
      redirect_valid = 1;
      redirect_pc = 32'h203;
      step();
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL rr_discard instr_valid=%b expected 0", instr_valid);
      end
      wait_req(32'h200, "rr_req200");
      step(); step();
      drain("rr_drain", 1, 32'h200);
   endtask

   task automatic test_stall();
      reset_all();
      imem_req_ready = 0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL stall_hold cycle %0d req_valid=%b addr=%h expected 1 00000000", i, imem_req_valid, imem_req_addr);
         end
         step();
      end
      redirect_valid = 1;
      redirect_pc = 32'h40;
      step();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
         failures++;
         $display("FAIL stall_redirect req_valid=%b addr=%h expected 1 00000040", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_redirect_fetch();
      reset_all();
      imem_req_ready = 1;
      instr_ready = 1;
      redirect_valid = 1;
      redirect_pc = 32'h80;
      step();
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL rf_drop req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid);
      end
      wait_req(32'h80, "rf_req80");
      step(); step();
      drain("rf_drain", 1, 32'h80);
   endtask

   task automatic test_wrap();
      reset_all();
      checks++;
      if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap_first req_valid=%b addr=%h expected 1 fffffffc", w_req_valid, w_req_addr);
      end
      @(posedge clk);
      #1;
      w_rsp_valid = 1;
      w_rsp_data = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      w_rsp_valid = 0;
      checks++;
      if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_instr !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL wrap_head valid=%b pc=%h instr=%h expected 1 fffffffc deadbeef", w_instr_valid, w_instr_pc, w_instr);
      end
      checks++;
      if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
         failures++;
         $display("FAIL wrap_next req_valid=%b addr=%h expected 1 00000000", w_req_valid, w_req_addr);
      end
   endtask

   task automatic test_reset_mid();
      reset_all();
      imem_req_ready = 1;
      instr_ready = 0;
      wait_req(32'h0, "rm_req0");
      step(); step();
      lat = 3;
      wait_req(32'h4, "rm_req4");
      step();
      checks++;
      if (instr_valid !== 1'b1) begin
         failures++;
         $display("FAIL rm_pre instr_valid=%b expected 1", instr_valid);
      end
      rst_n = 0;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
         failures++;
         $display("FAIL rm_async instr_valid=%b req_valid=%b addr=%h expected 0 0 00000000",
                  instr_valid, imem_req_valid, imem_req_addr);
      end
      reset_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_rsp();
      test_stall();
      test_redirect_fetch();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
